rs_issue: RTL and testbench

RS_ISSUE -- requirements
Module: rs_issue

---
 rtl/rs_issue_if.sv | 54 +++++
 rtl/rs_issue.sv | 150 +++++++++++++++
 tb/tb_rs_issue.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_issue_if.sv
// Dispatch, result-broadcast, flush and issue signals of the reservation station.
// The master modport belongs to whoever drives dispatch and the CDB.
// The slave modport belongs to the reservation station itself.
interface rs_issue_if #(
  parameter int NICK_W = 4
);
  logic              iDP_en;
  logic [31:0]       iDP_pc;
  logic [5:0]        iDP_op;
  logic [31:0]       iDP_imm;
  logic [NICK_W-1:0] iDP_rd_nick;
  logic              iDP_rs1_rdy;
  logic [31:0]       iDP_rs1_dt;
  logic [NICK_W-1:0] iDP_rs1_nick;
  logic              iDP_rs2_rdy;
  logic [31:0]       iDP_rs2_dt;
  logic [NICK_W-1:0] iDP_rs2_nick;

  logic              iEX_en;
  logic [NICK_W-1:0] iEX_nick;
  logic [31:0]       iEX_dt;
  logic              iSLB_en;
  logic [NICK_W-1:0] iSLB_nick;
  logic [31:0]       iSLB_dt;

  logic              iROB_clr;

  logic              oRS_en;
  logic [31:0]       oRS_pc;
  logic [5:0]        oRS_op;
  logic [31:0]       oRS_imm;
  logic [NICK_W-1:0] oRS_rd_nick;
  logic [31:0]       oRS_rs1_dt;
  logic [31:0]       oRS_rs2_dt;
  logic              oRS_full;

  modport master (
    output iDP_en, iDP_pc, iDP_op, iDP_imm, iDP_rd_nick,
           iDP_rs1_rdy, iDP_rs1_dt, iDP_rs1_nick,
           iDP_rs2_rdy, iDP_rs2_dt, iDP_rs2_nick,
           iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt, iROB_clr,
    input  oRS_en, oRS_pc, oRS_op, oRS_imm, oRS_rd_nick,
           oRS_rs1_dt, oRS_rs2_dt, oRS_full
  );

  modport slave (
    input  iDP_en, iDP_pc, iDP_op, iDP_imm, iDP_rd_nick,
           iDP_rs1_rdy, iDP_rs1_dt, iDP_rs1_nick,
           iDP_rs2_rdy, iDP_rs2_dt, iDP_rs2_nick,
           iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt, iROB_clr,
    output oRS_en, oRS_pc, oRS_op, oRS_imm, oRS_rd_nick,
           oRS_rs1_dt, oRS_rs2_dt, oRS_full
  );
endinterface

// File: rtl/rs_issue.sv
// Reservation station. Dispatch writes the lowest free slot, and the two CDB ports wake pending operands.
// Each cycle the lowest-index ready entry is issued into registered outputs.
module rs_issue #(
  parameter int RS_SIZE = 16,
  parameter int NICK_W  = 4
) (
  input logic      clk,
  input logic      rst,
  input logic      rdy,
  rs_issue_if.slave bus
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic              rdy;
    logic [NICK_W-1:0] nick;
    logic [31:0]       dt;
  } opnd_t;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [5:0]        op;
    logic [31:0]       imm;
    logic [NICK_W-1:0] rd_nick;
    opnd_t             rs1;
    opnd_t             rs2;
  } entry_t;

  entry_t ent [RS_SIZE];

  logic              is_en;
  logic [31:0]       is_pc;
  logic [5:0]        is_op;
  logic [31:0]       is_imm;
  logic [NICK_W-1:0] is_rd_nick;
  logic [31:0]       is_rs1_dt;
  logic [31:0]       is_rs2_dt;

  logic [RS_SIZE-1:0] valid_vec;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  opnd_t              dp_rs1;
  opnd_t              dp_rs2;

  // Capture a CDB result into a pending operand; the EX port wins when both carry the same nick.
  function automatic opnd_t wake(input opnd_t o,
                                 input logic ex_en, input logic [NICK_W-1:0] ex_nick,
                                 input logic [31:0] ex_dt,
                                 input logic slb_en, input logic [NICK_W-1:0] slb_nick,
                                 input logic [31:0] slb_dt);
    opnd_t r;
    r = o;
    if (!o.rdy) begin
      if (ex_en && ex_nick == o.nick) begin
        r.rdy = 1'b1;
        r.dt  = ex_dt;
      end else if (slb_en && slb_nick == o.nick) begin
        r.rdy = 1'b1;
        r.dt  = slb_dt;
      end
    end
    return r;
  endfunction

  // Find the lowest free slot and the lowest ready entry, both using start-of-cycle state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    valid_vec  = '0;
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      valid_vec[i] = ent[i].valid;
      if (!ent[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ent[i].valid && ent[i].rs1.rdy && ent[i].rs2.rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Build the incoming operands, forwarding any CDB result that appears in the dispatch cycle.
  always_comb begin
    dp_rs1 = wake('{rdy: bus.iDP_rs1_rdy, nick: bus.iDP_rs1_nick, dt: bus.iDP_rs1_dt},
                  bus.iEX_en, bus.iEX_nick, bus.iEX_dt, bus.iSLB_en, bus.iSLB_nick, bus.iSLB_dt);
    dp_rs2 = wake('{rdy: bus.iDP_rs2_rdy, nick: bus.iDP_rs2_nick, dt: bus.iDP_rs2_dt},
                  bus.iEX_en, bus.iEX_nick, bus.iEX_dt, bus.iSLB_en, bus.iSLB_nick, bus.iSLB_dt);
  end

  // Update the entry state and the issue register. Priority is reset, then flush, then normal operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    if (rst) begin
      // NOTE: only the valid bits are reset. An entry's payload is never read while its valid bit is clear.
      for (int i = 0; i < RS_SIZE; i++) ent[i].valid <= 1'b0;
      is_en      <= 1'b0;
      is_pc      <= '0;
      is_op      <= '0;
      is_imm     <= '0;
      is_rd_nick <= '0;
      is_rs1_dt  <= '0;
      is_rs2_dt  <= '0;
    end else if (rdy) begin
      if (bus.iROB_clr) begin
        for (int i = 0; i < RS_SIZE; i++) ent[i].valid <= 1'b0;
        is_en <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent[i].valid) begin
            ent[i].rs1 <= wake(ent[i].rs1, bus.iEX_en, bus.iEX_nick, bus.iEX_dt,
                               bus.iSLB_en, bus.iSLB_nick, bus.iSLB_dt);
            ent[i].rs2 <= wake(ent[i].rs2, bus.iEX_en, bus.iEX_nick, bus.iEX_dt,
                               bus.iSLB_en, bus.iSLB_nick, bus.iSLB_dt);
          end
        end
        is_en <= sel_found;
        if (sel_found) begin
          is_pc              <= ent[sel_idx].pc;
          is_op              <= ent[sel_idx].op;
          is_imm             <= ent[sel_idx].imm;
          is_rd_nick         <= ent[sel_idx].rd_nick;
          is_rs1_dt          <= ent[sel_idx].rs1.dt;
          is_rs2_dt          <= ent[sel_idx].rs2.dt;
          ent[sel_idx].valid <= 1'b0;
        end
        // The free slot was invalid at the start of the cycle, so it can never be the slot being issued.
        if (bus.iDP_en && free_found) begin
          ent[free_idx] <= '{valid: 1'b1, pc: bus.iDP_pc, op: bus.iDP_op, imm: bus.iDP_imm,
                             rd_nick: bus.iDP_rd_nick, rs1: dp_rs1, rs2: dp_rs2};
        end
      end
    end
  end

  assign bus.oRS_en      = is_en;
  assign bus.oRS_pc      = is_pc;
  assign bus.oRS_op      = is_op;
  assign bus.oRS_imm     = is_imm;
  assign bus.oRS_rd_nick = is_rd_nick;
  assign bus.oRS_rs1_dt  = is_rs1_dt;
  assign bus.oRS_rs2_dt  = is_rs2_dt;
  assign bus.oRS_full    = &valid_vec;
endmodule

// File: tb/tb_rs_issue.sv
// Directed bench for rs_issue. The expected values are worked out by hand from the intended behaviour.
module tb_rs_issue;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_tests = 0;
  int   n_fail  = 0;

  rs_issue_if #(.NICK_W(4)) bus ();

  rs_issue #(.RS_SIZE(16), .NICK_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log a mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then drop the single-cycle strobes.
  task automatic step();
    @(posedge clk);
    #1;
    bus.iDP_en   = 1'b0;
    bus.iEX_en   = 1'b0;
    bus.iSLB_en  = 1'b0;
    bus.iROB_clr = 1'b0;
  endtask

  task automatic dispatch(input logic [31:0] pc, input logic [5:0] op, input logic [31:0] imm,
                          input logic [3:0] rd,
                          input logic r1_rdy, input logic [3:0] r1_nick, input logic [31:0] r1_dt,
                          input logic r2_rdy, input logic [3:0] r2_nick, input logic [31:0] r2_dt);
    bus.iDP_en       = 1'b1;
    bus.iDP_pc       = pc;
    bus.iDP_op       = op;
    bus.iDP_imm      = imm;
    bus.iDP_rd_nick  = rd;
    bus.iDP_rs1_rdy  = r1_rdy;
    bus.iDP_rs1_nick = r1_nick;
    bus.iDP_rs1_dt   = r1_dt;
    bus.iDP_rs2_rdy  = r2_rdy;
    bus.iDP_rs2_nick = r2_nick;
    bus.iDP_rs2_dt   = r2_dt;
  endtask

  task automatic ex_bc(input logic [3:0] nick, input logic [31:0] dt);
    bus.iEX_en   = 1'b1;
    bus.iEX_nick = nick;
    bus.iEX_dt   = dt;
  endtask

  task automatic slb_bc(input logic [3:0] nick, input logic [31:0] dt);
    bus.iSLB_en   = 1'b1;
    bus.iSLB_nick = nick;
    bus.iSLB_dt   = dt;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.iDP_en = 1'b0; bus.iDP_pc = '0; bus.iDP_op = '0; bus.iDP_imm = '0; bus.iDP_rd_nick = '0;
    bus.iDP_rs1_rdy = 1'b0; bus.iDP_rs1_nick = '0; bus.iDP_rs1_dt = '0;
    bus.iDP_rs2_rdy = 1'b0; bus.iDP_rs2_nick = '0; bus.iDP_rs2_dt = '0;
    bus.iEX_en = 1'b0; bus.iEX_nick = '0; bus.iEX_dt = '0;
    bus.iSLB_en = 1'b0; bus.iSLB_nick = '0; bus.iSLB_dt = '0;
    bus.iROB_clr = 1'b0;

    // Reset state
    step(); step();
    rst = 1'b0;
    check("rst_en",   32'(bus.oRS_en), 32'd0);
    check("rst_full", 32'(bus.oRS_full), 32'd0);
    check("rst_pc",   bus.oRS_pc, 32'd0);
    check("rst_op",   32'(bus.oRS_op), 32'd0);
    check("rst_imm",  bus.oRS_imm, 32'd0);
    check("rst_rd",   32'(bus.oRS_rd_nick), 32'd0);
    check("rst_rs1",  bus.oRS_rs1_dt, 32'd0);
    check("rst_rs2",  bus.oRS_rs2_dt, 32'd0);

    // ADD with both operands ready: it issues one edge after the dispatch edge
    dispatch(32'h100, 6'h01, 32'h10, 4'd2, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
    step();
    check("add_lat0", 32'(bus.oRS_en), 32'd0);
    step();
    check("add_en",  32'(bus.oRS_en), 32'd1);
    check("add_op",  32'(bus.oRS_op), 32'h01);
    check("add_rs1", bus.oRS_rs1_dt, 32'd5);
    check("add_rs2", bus.oRS_rs2_dt, 32'd7);
    check("add_pc",  bus.oRS_pc, 32'h100);
    check("add_rd",  32'(bus.oRS_rd_nick), 32'd2);
    check("add_imm", bus.oRS_imm, 32'h10);
    step();
    check("add_freed", 32'(bus.oRS_en), 32'd0);
    check("hold_pc",   bus.oRS_pc, 32'h100);

    // rs1 waits on nick 3, which EX broadcasts later
    dispatch(32'h104, 6'h02, 32'h0, 4'd3, 1'b0, 4'd3, 32'd0, 1'b1, 4'd0, 32'h20);
    step(); step();
    check("wk_wait", 32'(bus.oRS_en), 32'd0);
    ex_bc(4'd3, 32'h10);
    step();
    check("wk_nobypass", 32'(bus.oRS_en), 32'd0);
    step();
    check("wk_en",  32'(bus.oRS_en), 32'd1);
    check("wk_rs1", bus.oRS_rs1_dt, 32'h10);
    check("wk_rs2", bus.oRS_rs2_dt, 32'h20);
    check("wk_pc",  bus.oRS_pc, 32'h104);

    // rs2 is forwarded from SLB in the dispatch cycle
    dispatch(32'h108, 6'h03, 32'h0, 4'd4, 1'b1, 4'd0, 32'd1, 1'b0, 4'd9, 32'd0);
    slb_bc(4'd9, 32'hABCD);
    step();
    step();
    check("fwd_en",  32'(bus.oRS_en), 32'd1);
    check("fwd_rs2", bus.oRS_rs2_dt, 32'hABCD);
    check("fwd_pc",  bus.oRS_pc, 32'h108);

    // Both CDB ports carry nick 5, so the EX data must win
    dispatch(32'h10C, 6'h04, 32'h0, 4'd5, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'd2);
    step();
    ex_bc(4'd5, 32'h111);
    slb_bc(4'd5, 32'h222);
    step();
    step();
    check("prio_en",  32'(bus.oRS_en), 32'd1);
    check("prio_rs1", bus.oRS_rs1_dt, 32'h111);

    // Fill all 16 slots; slot i waits on nick i
    for (int i = 0; i < 16; i++) begin
      dispatch(32'(i), 6'h05, 32'h0, 4'(i), 1'b0, 4'(i), 32'd0, 1'b1, 4'd0, 32'd0);
      step();
    end
    check("full_set",   32'(bus.oRS_full), 32'd1);
    check("full_noiss", 32'(bus.oRS_en), 32'd0);
    dispatch(32'hDEAD, 6'h06, 32'h0, 4'd0, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
    step();
    check("full_ign", 32'(bus.oRS_full), 32'd1);
    ex_bc(4'd4, 32'h44);
    step();
    check("full_wk", 32'(bus.oRS_en), 32'd0);
    // This dispatch must be dropped: the slot freed by this edge's issue is not reusable yet
    dispatch(32'hBEEF, 6'h06, 32'h0, 4'd0, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
    step();
    check("s4_en",   32'(bus.oRS_en), 32'd1);
    check("s4_pc",   bus.oRS_pc, 32'd4);
    check("s4_rs1",  bus.oRS_rs1_dt, 32'h44);
    check("s4_full", 32'(bus.oRS_full), 32'd0);
    dispatch(32'h500, 6'h07, 32'h0, 4'd1, 1'b1, 4'd0, 32'h55, 1'b1, 4'd0, 32'd0);
    step();
    check("refill_full", 32'(bus.oRS_full), 32'd1);
    step();
    check("refill_en",  32'(bus.oRS_en), 32'd1);
    check("refill_pc",  bus.oRS_pc, 32'h500);
    check("refill_rs1", bus.oRS_rs1_dt, 32'h55);
    step();
    check("no_beef", 32'(bus.oRS_en), 32'd0);
    bus.iROB_clr = 1'b1;
    step();
    check("clr1_full", 32'(bus.oRS_full), 32'd0);

    // Slots 2 and 6 wake together and issue in index order
    for (int i = 0; i < 7; i++) begin
      dispatch(32'h200 + 32'(i), 6'h08, 32'h0, 4'(i), 1'b0, 4'(i), 32'd0, 1'b1, 4'd0, 32'(i));
      step();
    end
    ex_bc(4'd2, 32'h2222);
    slb_bc(4'd6, 32'h6666);
    step();
    check("ord_wait", 32'(bus.oRS_en), 32'd0);
    step();
    check("ord1_en",  32'(bus.oRS_en), 32'd1);
    check("ord1_pc",  bus.oRS_pc, 32'h202);
    check("ord1_rs1", bus.oRS_rs1_dt, 32'h2222);
    step();
    check("ord2_en",  32'(bus.oRS_en), 32'd1);
    check("ord2_pc",  bus.oRS_pc, 32'h206);
    check("ord2_rs1", bus.oRS_rs1_dt, 32'h6666);
    // Flush 5 pending slots; the dispatch and wakeup in the flush cycle are ignored
    bus.iROB_clr = 1'b1;
    ex_bc(4'd0, 32'h1);
    dispatch(32'h999, 6'h09, 32'h0, 4'd0, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
    step();
    check("clr_en",   32'(bus.oRS_en), 32'd0);
    check("clr_full", 32'(bus.oRS_full), 32'd0);
    ex_bc(4'd0, 32'h1);
    slb_bc(4'd1, 32'h2);
    step();
    ex_bc(4'd3, 32'h3);
    step();
    check("clr_quiet1", 32'(bus.oRS_en), 32'd0);
    step();
    check("clr_quiet2", 32'(bus.oRS_en), 32'd0);

    // With rdy low, nothing moves and a broadcast is missed
    dispatch(32'h700, 6'h0A, 32'h0, 4'd7, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'h77);
    step();
    for (int i = 0; i < 3; i++) begin
      rdy = 1'b0;
      ex_bc(4'd7, 32'h70);
      step();
      check("stall_en", 32'(bus.oRS_en), 32'd0);
      check("stall_pc", bus.oRS_pc, 32'h206);
    end
    rdy = 1'b1;
    step(); step();
    check("stall_nocap", 32'(bus.oRS_en), 32'd0);
    ex_bc(4'd7, 32'h71);
    step();
    step();
    check("stall_en2", 32'(bus.oRS_en), 32'd1);
    check("stall_rs1", bus.oRS_rs1_dt, 32'h71);
    check("stall_pc2", bus.oRS_pc, 32'h700);
    rdy = 1'b0;
    step();
    check("stall_hold_en", 32'(bus.oRS_en), 32'd1);
    rdy = 1'b1;
    step();
    check("stall_rel", 32'(bus.oRS_en), 32'd0);

    // Reset while a ready entry is pending
    dispatch(32'h800, 6'h0B, 32'h0, 4'd8, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0, 32'd9);
    step();
    rst = 1'b1;
    step();
    check("mrst_en",   32'(bus.oRS_en), 32'd0);
    check("mrst_pc",   bus.oRS_pc, 32'd0);
    check("mrst_full", 32'(bus.oRS_full), 32'd0);
    rst = 1'b0;
    step();
    check("mrst_noiss", 32'(bus.oRS_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
